// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// A request is accepted in IDLE, its operands are held in registers that drive the
// ALU for one EXEC cycle, and the captured result is offered in RESP until the
// consumer takes it. When both requesters are valid, the pointer picks one. After
// each accept, the pointer moves to the requester that was not granted.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1)   requester handshakes, opcodes and operands
//   alu_in0, alu_in1, alu_op          operands and opcode to the shared ALU
//   alu_result, alu_zero              combinational ALU outputs
//   rsp_valid/ready/id/result/zero    response channel
//   busy                              high whenever not idle
//   op_count                          completed responses, wrapping

module alu_arbiter #(
    parameter int unsigned MAX_SIZE = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [2:0]          req0_op,
    input  logic [MAX_SIZE-1:0] req0_a,
    input  logic [MAX_SIZE-1:0] req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [2:0]          req1_op,
    input  logic [MAX_SIZE-1:0] req1_a,
    input  logic [MAX_SIZE-1:0] req1_b,
    output logic [MAX_SIZE-1:0] alu_in0,
    output logic [MAX_SIZE-1:0] alu_in1,
    output logic [2:0]          alu_op,
    input  logic [MAX_SIZE-1:0] alu_result,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [MAX_SIZE-1:0] rsp_result,
    output logic                rsp_zero,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [2:0]          op_q, op_d;
    logic [MAX_SIZE-1:0] a_q, a_d;
    logic [MAX_SIZE-1:0] b_q, b_d;
    logic                id_q, id_d;
    logic [MAX_SIZE-1:0] rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic grant_valid;
    logic grant_id;

    // With a single valid requester, grant_id is req1_valid; the pointer only decides ties.
    assign grant_valid = req0_valid | req1_valid;
    assign grant_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        cnt_d        = cnt_q;
        // Ready is held low during reset, even though the state already reads as idle.
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    req0_ready = rst_n & ~grant_id;
                    req1_ready = rst_n & grant_id;
                    op_d       = grant_id ? req1_op : req0_op;
                    a_d        = grant_id ? req1_a : req0_a;
                    b_d        = grant_id ? req1_b : req0_b;
                    id_d       = grant_id;
                    ptr_d      = ~grant_id;
                    state_d    = StExec;
                end
            end
            StExec: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = id_q;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign alu_in0    = a_q;
    assign alu_in1    = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = (state_q != StIdle);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The bench supplies an ALU and a timeline
// model of the arbiter, and it also checks tabled vectors and hand-written sequences.

module tb_alu_arbiter;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0]  alu_in0, alu_in1, alu_result, rsp_result;
    logic [2:0]    alu_op;
    logic          alu_zero, rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, busy;
    logic [CNT_W-1:0] op_count;

    alu_arbiter #(.MAX_SIZE(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), others a fixed marker.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op, alu_in0, alu_in1);
    assign alu_zero   = (alu_result == '0);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_age < 0 idle, 1 = one cycle after accept, 2 = response offered.
    int           m_age = -1;
    int           m_count = 0;
    logic         m_ptr = 1'b0;
    logic         m_id = 1'b0;
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;

    // Outputs sampled in the most recent cycle().
    logic         s_r0, s_r1, s_busy, s_valid, s_id, s_zero;
    logic [W-1:0] s_res;
    logic [CNT_W-1:0] s_cnt;

    task automatic model_reset();
        m_age = -1; m_count = 0; m_ptr = 1'b0; m_id = 1'b0;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    endtask

    // Inputs must already be set; checks outputs mid-cycle, then advances the model.
    task automatic cycle();
        logic g0, g1, gid;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_age < 0) begin
            g0 = req0_valid && (!req1_valid || !m_ptr);
            g1 = req1_valid && (!req0_valid || m_ptr);
        end
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("busy", busy, m_age >= 1);
        chk("rsp_valid", rsp_valid, m_age >= 2);
        chk("op_count", op_count, m_count % (1 << CNT_W));
        chk("alu_in0", alu_in0, m_a);
        chk("alu_in1", alu_in1, m_b);
        chk("alu_op", alu_op, m_op);
        if (m_age >= 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", rsp_zero, m_res == '0);
        end
        s_r0 = req0_ready; s_r1 = req1_ready; s_busy = busy; s_valid = rsp_valid;
        s_id = rsp_id; s_zero = rsp_zero; s_res = rsp_result; s_cnt = op_count;
        if (g0 || g1) begin
            gid   = g1;
            m_op  = gid ? req1_op : req0_op;
            m_a   = gid ? req1_a : req0_a;
            m_b   = gid ? req1_b : req0_b;
            m_res = ref_alu(m_op, m_a, m_b);
            m_id  = gid;
            m_ptr = !gid;
            m_age = 1;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age >= 2 && rsp_ready) begin
            m_age = -1;
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst op_count", op_count, 0);
        chk("rst rsp_result", rsp_result, 0);
        chk("rst rsp_zero", rsp_zero, 0);
        chk("rst rsp_id", rsp_id, 0);
        chk("rst alu_in0", alu_in0, 0);
        chk("rst alu_op", alu_op, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) cycle();
    endtask

    typedef struct {
        logic         v0;
        logic [2:0]   op0;
        logic [W-1:0] a0, b0;
        logic         v1;
        logic [2:0]   op1;
        logic [W-1:0] a1, b1;
        logic         exp_id;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Both valid x3 (tie rounds), SLT both ways, undefined opcode, ADD wrap to zero.
        vecs[0] = '{1, 3'd1, 9, 9, 1, 3'd2, 32'hF0, 32'h0F, 0, 0, 1};
        vecs[1] = '{1, 3'd1, 9, 9, 1, 3'd2, 32'hF0, 32'h0F, 1, 0, 1};
        vecs[2] = '{1, 3'd1, 9, 9, 1, 3'd2, 32'hF0, 32'h0F, 0, 0, 1};
        vecs[3] = '{0, 3'd0, 0, 0, 1, 3'd5, 32'hFFFF_FFFF, 1, 1, 1, 0};
        vecs[4] = '{1, 3'd5, 1, 32'hFFFF_FFFF, 0, 3'd0, 0, 0, 0, 0, 1};
        vecs[5] = '{1, 3'd6, 3, 4, 0, 3'd0, 0, 0, 0, 32'hDEAD_BEEF, 0};
        vecs[6] = '{0, 3'd0, 0, 0, 1, 3'd0, 32'hFFFF_FFFF, 1, 1, 0, 1};

        do_reset();

        // Single request: rsp_valid two cycles after the accept, then back to idle.
        req0_valid = 1; req0_op = 3'd0; req0_a = 5; req0_b = 7; rsp_ready = 1;
        cycle();
        chk("lat accept", s_r0, 1);
        req0_valid = 0;
        cycle();
        chk("lat N+1 rsp_valid", s_valid, 0);
        cycle();
        chk("lat N+2 rsp_valid", s_valid, 1);
        chk("lat rsp_id", s_id, 0);
        chk("lat rsp_result", s_res, 12);
        chk("lat rsp_zero", s_zero, 0);
        cycle();
        chk("lat N+3 busy", s_busy, 0);
        chk("lat op_count", s_cnt, 1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            req0_valid = vecs[i].v0; req0_op = vecs[i].op0;
            req0_a = vecs[i].a0; req0_b = vecs[i].b0;
            req1_valid = vecs[i].v1; req1_op = vecs[i].op1;
            req1_a = vecs[i].a1; req1_b = vecs[i].b1;
            rsp_ready = 1;
            cycle();
            chk($sformatf("vec%0d ready0", i), s_r0, !vecs[i].exp_id);
            chk($sformatf("vec%0d ready1", i), s_r1, vecs[i].exp_id);
            req0_valid = 0; req1_valid = 0;
            cycle();
            cycle();
            chk($sformatf("vec%0d rsp_valid", i), s_valid, 1);
            chk($sformatf("vec%0d rsp_id", i), s_id, vecs[i].exp_id);
            chk($sformatf("vec%0d rsp_result", i), s_res, vecs[i].exp_res);
            chk($sformatf("vec%0d rsp_zero", i), s_zero, vecs[i].exp_zero);
        end

        // Backpressure, with operands changing and a competing request while busy.
        drain();
        req0_valid = 1; req0_op = 3'd3; req0_a = 32'hF0; req0_b = 32'h0F; rsp_ready = 0;
        cycle();
        req0_valid = 0; req0_a = 32'h123; req1_valid = 1; req1_op = 3'd0;
        req1_a = 2; req1_b = 3;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp rsp_valid", s_valid, 1);
            chk("bp rsp_result", s_res, 32'hFF);
            chk("bp readies", {s_r0, s_r1}, 2'b00);
            chk("bp busy", s_busy, 1);
        end
        rsp_ready = 1;
        cycle();
        cycle();
        chk("bp idle after release", s_busy, 0);
        chk("bp req1 granted", s_r1, 1);
        drain();

        // Reset while executing: in-flight op is dropped.
        req0_valid = 1; req0_op = 3'd0; req0_a = 1; req0_b = 1; rsp_ready = 1;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rstx busy", busy, 0);
        chk("rstx rsp_valid", rsp_valid, 0);
        chk("rstx req0_ready", req0_ready, 0);
        chk("rstx op_count", op_count, 0);
        model_reset();
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cycle();

        // Random traffic until the 4-bit counter wraps, then more random traffic.
        begin
            int cyc;
            cyc = 0;
            do_reset();
            while (m_count < 16 && cyc < 3000) begin
                req0_valid = ($urandom_range(0, 9) < 7); req1_valid = ($urandom_range(0, 9) < 7);
                req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
                req0_a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                req1_a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                rsp_ready = ($urandom_range(0, 1) == 1);
                cycle();
                cyc++;
            end
            chk("wrap reached 16 ops", m_count, 16);
            req0_valid = 0; req1_valid = 0;
            cycle();
            chk("wrap op_count", s_cnt, 0);
            for (int i = 0; i < 400; i++) begin
                req0_valid = ($urandom_range(0, 1) == 1); req1_valid = ($urandom_range(0, 1) == 1);
                req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
                req0_a = $urandom; req0_b = ($urandom_range(0, 2) == 0) ? req0_a : $urandom;
                req1_a = $urandom; req1_b = ($urandom_range(0, 2) == 0) ? req1_a : $urandom;
                rsp_ready = ($urandom_range(0, 2) != 0);
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
